// File: rtl/evt_stream_rcv16.sv
// evt_stream_rcv16: serial event-word receiver feeding a sync-RAM FIFO with a prefetched head register
module evt_stream_rcv16 #(
  parameter int AW = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          DataStream,
  input  logic          ClrErr,
  input  logic          Ready,
  output logic [15:0]   DataOut,
  output logic          Valid,
  output logic [AW:0]   Count,
  output logic          Overflow,
  output logic          FrameErr
);
  typedef enum logic [1:0] {Idle, Shift, Stop} state_t;
  state_t r_state, w_state_nxt;
  logic [3:0] r_bit, w_bit_nxt;
  logic [15:0] r_shift, w_shift_nxt;
  logic w_push, w_bad;
  logic [15:0] r_mem [2**AW];
  logic [AW-1:0] r_wr, r_rd, w_rd_nxt;
  logic [AW:0] r_count;
  logic [15:0] r_dout, w_dout_nxt;
  logic r_ovf, r_ferr;
  logic w_full, w_empty, w_single, w_pop, w_wr;
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= Idle;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_bad       = 1'b0;
    case (r_state)
      Idle: begin
        w_state_nxt = DataStream ? Shift : Idle;
        w_bit_nxt   = DataStream ? 4'd0 : r_bit;
      end
      Shift: begin
        w_shift_nxt = {r_shift[14:0], DataStream};
        w_bit_nxt   = r_bit + 4'd1;
        w_state_nxt = (r_bit == 4'd15) ? Stop : Shift;
      end
      Stop: begin
        w_push      = ~DataStream;
        w_bad       = DataStream;
        w_state_nxt = Idle;
      end
      default: w_state_nxt = Idle;
    endcase
  end
  assign w_full   = r_count[AW];
  assign w_empty  = (r_count == '0);
  assign w_single = (r_count == (AW+1)'(1));
  assign w_pop    = Valid & Ready;
  assign w_wr     = w_push & (~w_full | w_pop);
  assign w_rd_nxt = r_rd + AW'(1);
  // Head register is the RAM read register; a push into an emptying FIFO bypasses the RAM.
  assign w_dout_nxt = (w_pop & ~w_single) ? r_mem[w_rd_nxt] :
                      (w_wr & (w_empty | (w_pop & w_single))) ? r_shift : r_dout;
  always_ff @(posedge Clock) begin
    if (w_wr) r_mem[r_wr] <= r_shift;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_dout  <= '0;
      r_ovf   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_wr    <= w_wr ? r_wr + AW'(1) : r_wr;
      r_rd    <= w_pop ? w_rd_nxt : r_rd;
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      r_dout  <= w_dout_nxt;
      r_ovf   <= (w_push & w_full & ~w_pop) | (r_ovf & ~ClrErr);
      r_ferr  <= w_bad | (r_ferr & ~ClrErr);
    end
  end
  assign DataOut  = r_dout;
  assign Valid    = ~w_empty;
  assign Count    = r_count;
  assign Overflow = r_ovf;
  assign FrameErr = r_ferr;
endmodule

// File: tb/tb_evt_stream_rcv16.sv
// tb_evt_stream_rcv16: directed and random frames checked against a queue-based FIFO model
module tb_evt_stream_rcv16;
  logic Clock = 1'b0, Reset = 1'b1, DataStream = 1'b0, ClrErr = 1'b0, Ready = 1'b0;
  logic [15:0] DataOut;
  logic Valid, Overflow, FrameErr;
  logic [4:0] Count;
  int n_cmp = 0, n_bad = 0;
  int rdy_pct = 0, clr_pct = 0;
  logic force_rdy = 1'b0, force_clr = 1'b0;
  logic t_good = 1'b0, t_bad = 1'b0;
  logic [15:0] t_word = '0;
  logic [15:0] q[$];
  logic m_ovf = 1'b0, m_ferr = 1'b0;
  evt_stream_rcv16 #(.AW(4)) dut (
    .Clock(Clock), .Reset(Reset), .DataStream(DataStream), .ClrErr(ClrErr), .Ready(Ready),
    .DataOut(DataOut), .Valid(Valid), .Count(Count), .Overflow(Overflow), .FrameErr(FrameErr)
  );
  always #5 Clock = ~Clock;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: the bench knows which cycle is a stop cycle, so the FIFO is just a queue.
  always @(posedge Clock) begin
    int sz;
    logic pop;
    if (Reset) begin
      q.delete();
      m_ovf = 1'b0;
      m_ferr = 1'b0;
    end else begin
      sz = q.size();
      pop = (sz > 0) && Ready;
      if (pop) void'(q.pop_front());
      if (t_good && (sz < 16 || pop)) q.push_back(t_word);
      m_ovf = (t_good && sz == 16 && !pop) || (m_ovf && !ClrErr);
      m_ferr = t_bad || (m_ferr && !ClrErr);
    end
    #1;
    check("valid", Valid, q.size() > 0);
    check("count", Count, q.size());
    check("overflow", Overflow, m_ovf);
    check("frameerr", FrameErr, m_ferr);
    if (q.size() > 0) check("dataout", DataOut, q[0]);
  end
  task automatic cyc(input logic b, input logic sg, input logic sb, input logic [15:0] w, input logic rst);
    @(negedge Clock);
    DataStream = b;
    Reset = rst;
    t_good = sg;
    t_bad = sb;
    t_word = w;
    Ready = force_rdy || ($urandom_range(99) < rdy_pct);
    ClrErr = force_clr || ($urandom_range(99) < clr_pct);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask
  task automatic send_frame(input logic [15:0] w, input logic sb, input logic stop_rdy);
    cyc(1'b1, 1'b0, 1'b0, w, 1'b0);
    for (int i = 15; i >= 0; i--) cyc(w[i], 1'b0, 1'b0, w, 1'b0);
    force_rdy = stop_rdy;
    cyc(sb, !sb, sb, w, 1'b0);
    force_rdy = 1'b0;
  endtask
  task automatic settle();
    @(posedge Clock);
    #2;
  endtask
  task automatic drain();
    force_rdy = 1'b1;
    idle(18);
    force_rdy = 1'b0;
    idle(1);
  endtask
  initial begin
    logic [15:0] w;
    int k, r;
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    settle();
    check("rst_valid", Valid, 0);
    check("rst_count", Count, 0);
    check("rst_dataout", DataOut, 16'h0000);
    check("rst_flags", {Overflow, FrameErr}, 0);
    idle(2);
    send_frame(16'hA5C3, 1'b0, 1'b0);
    settle();
    check("a5c3_valid", Valid, 1);
    check("a5c3_data", DataOut, 16'hA5C3);
    check("a5c3_count", Count, 1);
    drain();
    send_frame(16'h0001, 1'b0, 1'b0);
    send_frame(16'hFFFF, 1'b0, 1'b0);
    settle();
    check("b2b_count2", Count, 2);
    check("b2b_head0", DataOut, 16'h0001);
    force_rdy = 1'b1;
    idle(1);
    settle();
    check("b2b_head1", DataOut, 16'hFFFF);
    check("b2b_count1", Count, 1);
    idle(1);
    settle();
    check("b2b_count0", Count, 0);
    check("b2b_valid0", Valid, 0);
    force_rdy = 1'b0;
    idle(1);
    send_frame(16'h1234, 1'b1, 1'b0);
    settle();
    check("ferr_set", FrameErr, 1);
    check("ferr_count", Count, 0);
    send_frame(16'h5678, 1'b0, 1'b0);
    settle();
    check("ferr_next_data", DataOut, 16'h5678);
    check("ferr_next_count", Count, 1);
    force_clr = 1'b1;
    idle(1);
    force_clr = 1'b0;
    settle();
    check("ferr_clr", FrameErr, 0);
    drain();
    for (int i = 0; i < 17; i++) send_frame(16'(i), 1'b0, 1'b0);
    settle();
    check("ovf_count", Count, 16);
    check("ovf_flag", Overflow, 1);
    force_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_popseq", DataOut, i);
      idle(1);
      settle();
    end
    check("ovf_empty", Valid, 0);
    force_rdy = 1'b0;
    force_clr = 1'b1;
    idle(1);
    force_clr = 1'b0;
    settle();
    check("ovf_clr", Overflow, 0);
    for (int i = 0; i < 16; i++) send_frame(16'(100 + i), 1'b0, 1'b0);
    send_frame(16'hBEEF, 1'b0, 1'b1);
    settle();
    check("full_pp_count", Count, 16);
    check("full_pp_ovf", Overflow, 0);
    check("full_pp_head", DataOut, 101);
    force_rdy = 1'b1;
    idle(15);
    settle();
    check("full_pp_last", DataOut, 16'hBEEF);
    check("full_pp_last_cnt", Count, 1);
    idle(1);
    force_rdy = 1'b0;
    idle(1);
    w = 16'hC3C3;
    cyc(1'b1, 1'b0, 1'b0, w, 1'b0);
    for (int i = 15; i > 7; i--) cyc(w[i], 1'b0, 1'b0, w, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    send_frame(16'h00FF, 1'b0, 1'b0);
    settle();
    check("rstmid_count", Count, 1);
    check("rstmid_data", DataOut, 16'h00FF);
    drain();
    clr_pct = 3;
    for (int n = 0; n < 160; n++) begin
      if (n % 25 == 0) begin
        r = $urandom_range(2);
        rdy_pct = (r == 0) ? 5 : (r == 1) ? 40 : 90;
      end
      w = 16'($urandom);
      r = $urandom_range(99);
      if (r < 4) begin
        k = $urandom_range(1, 16);
        cyc(1'b1, 1'b0, 1'b0, w, 1'b0);
        for (int j = 0; j < k - 1; j++) cyc(w[15 - j], 1'b0, 1'b0, w, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      end else begin
        send_frame(w, r > 88, 1'($urandom_range(1)));
      end
      idle($urandom_range(0, 2));
    end
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/evt_stream_rcv16.md
EVT_STREAM_RCV16 -- requirements
Module: evt_stream_rcv16

Interface
REQ-001 Parameter: AW, default 4, FIFO address width; FIFO depth is 2**AW words.
REQ-002 Clock  input  1  clock; all logic updates on the rising edge.
REQ-003 Reset  input  1  reset; synchronous, active-high.
REQ-004 DataStream  input  1  serial event-word stream, one bit per Clock, idle low.
REQ-005 ClrErr  input  1  single-cycle pulse; clears the sticky error flags.
REQ-006 Ready  input  1  downstream can accept DataOut this cycle.
REQ-007 DataOut  output  16  word at the FIFO head, valid when Valid=1.
REQ-008 Valid  output  1  FIFO non-empty.
REQ-009 Count  output  AW+1  number of words held in the FIFO.
REQ-010 Overflow  output  1  sticky; a good word was dropped because the FIFO was full.
REQ-011 FrameErr  output  1  sticky; a frame ended with a bad stop bit.

Function
REQ-012 The frame format SHALL be: start bit 1, then 16 data bits MSB first, then stop bit 0; one bit per cycle; frames may be back-to-back.
REQ-013 The receiver state machine SHALL have exactly the states Idle, Shift and Stop.
REQ-014 Idle: when DataStream=1 the machine SHALL go to Shift with bit counter 0; otherwise it SHALL stay in Idle.
REQ-015 Shift: each cycle it SHALL shift DataStream into the LSB of a 16-bit shift register and increment the bit counter.
REQ-016 Shift: after the 16th data bit is sampled (counter=15) the machine SHALL go to Stop.
REQ-017 Stop: if DataStream=0 the assembled word SHALL be pushed into the FIFO; the machine SHALL then return to Idle.
REQ-018 Stop: if DataStream=1 the word SHALL be discarded, FrameErr SHALL be set, and the machine SHALL return to Idle.
REQ-019 The minimum frame period SHALL be 18 cycles: a start bit in the cycle after Stop SHALL be accepted.
REQ-020 Latency: Valid SHALL be 1 in the cycle after the Stop cycle that pushes a word into an empty FIFO, with DataOut equal to that word.
REQ-021 Pop SHALL occur on a rising edge where Valid=1 and Ready=1; DataOut SHALL present the next word in the following cycle.
REQ-022 Ready while Valid=0 SHALL have no effect.
REQ-023 When the FIFO is full and a push occurs with no pop in the same cycle, the word SHALL be dropped, Overflow SHALL be set, and FIFO contents and Count SHALL be unchanged.
REQ-024 When the FIFO is full and a push and a pop occur in the same cycle, both SHALL succeed and Count SHALL stay 2**AW.
REQ-025 A simultaneous push and pop at any other occupancy SHALL leave Count unchanged.
REQ-026 Write and read pointers SHALL be AW bits wide and wrap modulo 2**AW.
REQ-027 Count SHALL never exceed 2**AW and SHALL never underflow.
REQ-028 ClrErr SHALL clear Overflow and FrameErr on the next edge.
REQ-029 If an error condition occurs in the same cycle as ClrErr, the flag SHALL be set (set wins).
REQ-030 FIFO storage SHALL be a synchronous RAM with registered read, with DataOut meeting REQ-020 and REQ-021 timing.

Reset
REQ-031 Reset SHALL put the state machine in Idle and clear the bit counter, the pointers and Count.
REQ-032 Reset SHALL clear Overflow, FrameErr, Valid and DataOut (value 0).
REQ-033 Reset mid-frame SHALL abandon the partial word; no push SHALL occur for it.
REQ-034 Reset SHALL take priority over all other inputs.
REQ-035 RAM contents SHALL NOT require reset.

Verification
REQ-036 Frame 1,0xA5C3,0 with Ready=0 -> Valid=1 one cycle after the stop bit; DataOut=0xA5C3; Count=1.
REQ-037 Two back-to-back frames 0x0001, 0xFFFF (36 cycles), then Ready=1 for 2 cycles -> DataOut 0x0001 then 0xFFFF; Count goes 2,1,0; Valid then drops.
REQ-038 Frame 0x1234 with stop bit 1 -> FrameErr=1; Count unchanged; the next good frame 0x5678 is received correctly; a ClrErr pulse then clears FrameErr.
REQ-039 With AW=4, 17 frames (data 0..16) and Ready=0 -> Count=16; Overflow=1; popping all words yields 0..15; word 16 is lost.
REQ-040 FIFO full, with Ready=1 held during the stop cycle of frame 0xBEEF -> Count stays 16; Overflow stays 0; 0xBEEF is popped last.
REQ-041 Reset asserted at bit 8 of a frame, then a new frame 0x00FF -> only 0x00FF appears; Count=1.
